axi_lite_slave_example_regs: RTL and testbench



---
 rtl/axi_lite_slave_example_regs_pkg.sv | 45 ++++
 rtl/axi_lite_slave_example_regs_ctrl.sv | 112 +++++++++++
 rtl/axi_lite_slave_example_regs.sv | 146 ++++++++++++++
 tb/tb_axi_lite_slave_example_regs.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_slave_example_regs_pkg.sv
// Shared definitions for the axi_lite_slave_example register block.
// - Word offsets of every register (byte address >> 2)
// - AXI response code
// - Write request bundle passed from the handshake controller to the
//   register file
// - Byte-lane merge helper
package axi_lite_slave_example_regs_pkg;

    localparam int WORD_W = 14;
    typedef logic [WORD_W-1:0] word_addr_t;

    localparam word_addr_t ADDR_MAGIC         = 14'h00;
    localparam word_addr_t ADDR_VERSION       = 14'h01;
    localparam word_addr_t ADDR_FEATURE_FLAGS = 14'h02;
    localparam word_addr_t ADDR_GIT_HASH      = 14'h03;
    localparam word_addr_t ADDR_BUILD_TIME_LO = 14'h04;
    localparam word_addr_t ADDR_BUILD_TIME_HI = 14'h05;
    localparam word_addr_t ADDR_ENABLE        = 14'h08;
    localparam word_addr_t ADDR_OUTPUT_EN_LO  = 14'h09;
    localparam word_addr_t ADDR_OUTPUT_EN_HI  = 14'h0A;
    localparam word_addr_t ADDR_RING_COUNT    = 14'h0B;
    localparam word_addr_t ADDR_RING_COUNTA   = 14'h0C;
    localparam word_addr_t ADDR_RING_COUNTB   = 14'h0D;

    localparam logic [1:0] OKAY = 2'b00;

    typedef struct packed {
        logic        en;
        word_addr_t  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_strb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_slave_example_regs_ctrl.sv
// AXI4-Lite handshake controller for the example register block.
// Ports:
//   clk/rst               clock, asynchronous active-high reset
//   aw*/w*/b*             write address, data and response channels
//   ar*/r*valid/rready    read address channel and read valid handshake
//   wr_req                one-cycle write request (en, word addr, data, strb)
//   rd_en/rd_addr         one-cycle strobe telling the top to capture rdata
module axi_lite_slave_example_regs_ctrl
    import axi_lite_slave_example_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int ADDR_MSB   = 15,
    parameter int ADDR_LSB   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic                  rvalid,
    input  logic                  rready,
    output wr_req_t               wr_req,
    output logic                  rd_en,
    output word_addr_t            rd_addr
);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

    wr_state_t wstate;
    rd_state_t rstate;

    // Sub-word address bits carry no information for a 32-bit word map.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

    // Write side: accept only when both address and data are presented,
    // and never while a response is still waiting for bready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: if (awvalid && wvalid) begin
                    wstate  <= W_ACK;
                    awready <= 1'b1;
                    wready  <= 1'b1;
                end
                W_ACK: if (awvalid && wvalid) begin
                    wstate  <= W_RESP;
                    awready <= 1'b0;
                    wready  <= 1'b0;
                    bvalid  <= 1'b1;
                end
                W_RESP: if (bready) begin
                    wstate <= W_IDLE;
                    bvalid <= 1'b0;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: if (arvalid) begin
                    rstate  <= R_ACK;
                    arready <= 1'b1;
                end
                R_ACK: if (arvalid) begin
                    rstate  <= R_DATA;
                    arready <= 1'b0;
                    rvalid  <= 1'b1;
                end
                R_DATA: if (rready) begin
                    rstate <= R_IDLE;
                    rvalid <= 1'b0;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Strobes fire on the handshake edge itself.
    always_comb begin
        wr_req.en   = (wstate == W_ACK) && awvalid && wvalid;
        wr_req.addr = awaddr[ADDR_MSB:ADDR_LSB];
        wr_req.data = wdata;
        wr_req.strb = wstrb;
    end

    assign rd_en   = (rstate == R_ACK) && arvalid;
    assign rd_addr = araddr[ADDR_MSB:ADDR_LSB];

endmodule

// File: rtl/axi_lite_slave_example_regs.sv
// AXI4-Lite control/status register block for axi_lite_slave_example.
// Ports:
//   s_axi_aclk            clock
//   s_axi_aresetn         asynchronous reset, active-high despite the name
//   s_axi_aw*/w*/b*       AXI4-Lite write channels (bresp always OKAY)
//   s_axi_ar*/r*          AXI4-Lite read channels (rresp always OKAY)
//   enable/output_en/ring_count   RW register contents driven to fabric
//   ring_counta/ring_countb       status from fabric, sampled on read
module axi_lite_slave_example_regs
    import axi_lite_slave_example_regs_pkg::*;
#(
    parameter logic [31:0] MAGIC               = 32'h21EAF,
    parameter logic [31:0] VERSION             = 32'h0,
    parameter logic [31:0] FEATURE_FLAGS       = 32'h0,
    parameter logic [31:0] GIT_HASH            = 32'h0,
    parameter logic [63:0] BUILD_TIME          = 64'h0,
    parameter logic        DEFAULT_ENABLE      = 1'h0,
    parameter logic [32:0] DEFAULT_OUTPUT_EN   = 33'h0,
    parameter logic [15:0] DEFAULT_RING_COUNT  = 16'h0,
    parameter logic [15:0] DEFAULT_RING_COUNTA = 16'h0,
    parameter logic [15:0] DEFAULT_RING_COUNTB = 16'h0,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int C_S_AXI_ADDR_MSB   = 15,
    parameter int C_S_AXI_ADDR_LSB   = 2
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            enable,
    output logic [32:0]                     output_en,
    output logic [15:0]                     ring_count,
    input  logic [15:0]                     ring_counta,
    input  logic [15:0]                     ring_countb
);

    logic       rst;
    wr_req_t    wr_req;
    logic       rd_en;
    word_addr_t rd_addr;
    logic [31:0] rd_mux;

    assign rst = s_axi_aresetn;

    // Protection bits and the status-default parameters have no effect here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, s_axi_awprot, s_axi_arprot,
                             DEFAULT_RING_COUNTA, DEFAULT_RING_COUNTB};

    axi_lite_slave_example_regs_ctrl #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .ADDR_MSB   (C_S_AXI_ADDR_MSB),
        .ADDR_LSB   (C_S_AXI_ADDR_LSB)
    ) u_ctrl (
        .clk     (s_axi_aclk),
        .rst     (rst),
        .awaddr  (s_axi_awaddr),
        .awvalid (s_axi_awvalid),
        .awready (s_axi_awready),
        .wdata   (s_axi_wdata),
        .wstrb   (s_axi_wstrb),
        .wvalid  (s_axi_wvalid),
        .wready  (s_axi_wready),
        .bvalid  (s_axi_bvalid),
        .bready  (s_axi_bready),
        .araddr  (s_axi_araddr),
        .arvalid (s_axi_arvalid),
        .arready (s_axi_arready),
        .rvalid  (s_axi_rvalid),
        .rready  (s_axi_rready),
        .wr_req  (wr_req),
        .rd_en   (rd_en),
        .rd_addr (rd_addr)
    );

    assign s_axi_bresp = OKAY;
    assign s_axi_rresp = OKAY;

    // RW registers; RO and unmapped words fall through to default.
    always_ff @(posedge s_axi_aclk or posedge rst) begin
        if (rst) begin
            enable     <= DEFAULT_ENABLE;
            output_en  <= DEFAULT_OUTPUT_EN;
            ring_count <= DEFAULT_RING_COUNT;
        end else if (wr_req.en) begin
            case (wr_req.addr)
                ADDR_ENABLE:
                    if (wr_req.strb[0]) enable <= wr_req.data[0];
                ADDR_OUTPUT_EN_LO:
                    output_en[31:0] <= merge_strb(output_en[31:0], wr_req.data, wr_req.strb);
                ADDR_OUTPUT_EN_HI:
                    if (wr_req.strb[0]) output_en[32] <= wr_req.data[0];
                ADDR_RING_COUNT: begin
                    if (wr_req.strb[0]) ring_count[7:0]  <= wr_req.data[7:0];
                    if (wr_req.strb[1]) ring_count[15:8] <= wr_req.data[15:8];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        case (rd_addr)
            ADDR_MAGIC:         rd_mux = MAGIC;
            ADDR_VERSION:       rd_mux = VERSION;
            ADDR_FEATURE_FLAGS: rd_mux = FEATURE_FLAGS;
            ADDR_GIT_HASH:      rd_mux = GIT_HASH;
            ADDR_BUILD_TIME_LO: rd_mux = BUILD_TIME[31:0];
            ADDR_BUILD_TIME_HI: rd_mux = BUILD_TIME[63:32];
            ADDR_ENABLE:        rd_mux = {31'h0, enable};
            ADDR_OUTPUT_EN_LO:  rd_mux = output_en[31:0];
            ADDR_OUTPUT_EN_HI:  rd_mux = {31'h0, output_en[32]};
            ADDR_RING_COUNT:    rd_mux = {16'h0, ring_count};
            ADDR_RING_COUNTA:   rd_mux = {16'h0, ring_counta};
            ADDR_RING_COUNTB:   rd_mux = {16'h0, ring_countb};
            default:            rd_mux = 32'h0;
        endcase
    end

    // Captured on the read handshake edge, so a write landing on the same
    // edge is not yet visible.
    always_ff @(posedge s_axi_aclk or posedge rst) begin
        if (rst)        s_axi_rdata <= '0;
        else if (rd_en) s_axi_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_axi_lite_slave_example_regs.sv
module tb_axi_lite_slave_example_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        enable;
    logic [32:0] output_en;
    logic [15:0] ring_count, ring_counta, ring_countb;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_lite_slave_example_regs dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .enable        (enable),
        .output_en     (output_en),
        .ring_count    (ring_count),
        .ring_counta   (ring_counta),
        .ring_countb   (ring_countb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_start(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
    endtask

    // Returns number of negedges until awready&&wready seen.
    task automatic wr_wait_accept(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(awready && wready) && lat < 20);
        if (!(awready && wready)) check("aw_accept_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wr_wait_resp(output logic [1:0] resp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bvalid && n < 20);
        if (!bvalid) check("bvalid_timeout", 0, 1);
        resp = bresp;
    endtask

    task automatic axi_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int lat;
        logic [1:0] resp;
        bready = 1'b1;
        wr_start(a, d, s);
        wr_wait_accept(lat);
        wr_wait_resp(resp);
        @(posedge clk); #1;
    endtask

    task automatic rd_wait_accept(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!arready && lat < 20);
        if (!arready) check("ar_accept_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic rd_wait_data(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rvalid && lat < 20);
        if (!rvalid) check("rvalid_timeout", 0, 1);
    endtask

    task automatic axi_rd(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat_ar, output int lat_r);
        rready = 1'b1;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        rd_wait_accept(lat_ar);
        rd_wait_data(lat_r);
        d = rdata; resp = rresp;
        @(posedge clk); #1;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  resp;
        int la, lr;
        axi_rd(a, d, resp, la, lr);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        int la, lr;

        rst = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0; ring_counta = '0; ring_countb = '0;
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_enable", enable, 0);
        check("rst_output_en", output_en, 0);
        check("rst_ring_count", ring_count, 0);
        rst = 1'b0;

        // Identity constants and read latency
        axi_rd(16'h0000, d, resp, la, lr);
        check("magic", d, 32'h00021EAF);
        check("magic_rresp", resp, 2'b00);
        check("ar_latency", la, 1);
        check("r_latency", lr, 1);
        rd_check("version", 16'h0004, 0);
        rd_check("feature", 16'h0008, 0);
        rd_check("git_hash", 16'h000C, 0);
        rd_check("build_lo", 16'h0010, 0);
        rd_check("build_hi", 16'h0014, 0);

        // RW registers, with write latency check on the first one
        bready = 1'b1;
        wr_start(16'h0020, 32'h1, 4'hF);
        wr_wait_accept(la);
        check("aw_latency", la, 1);
        check("bvalid_after_hs", bvalid, 1);
        wr_wait_resp(resp);
        check("bresp", resp, 2'b00);
        @(posedge clk); #1;
        check("bvalid_cleared", bvalid, 0);
        axi_wr(16'h0024, 32'hFFFFFFFF, 4'hF);
        axi_wr(16'h0028, 32'h1, 4'hF);
        axi_wr(16'h002C, 32'h1234, 4'hF);
        check("enable", enable, 1);
        check("output_en", output_en, 33'h1FFFFFFFF);
        check("ring_count", ring_count, 16'h1234);
        rd_check("rd_enable", 16'h0020, 32'h1);
        rd_check("rd_outen_lo", 16'h0024, 32'hFFFFFFFF);
        rd_check("rd_outen_hi", 16'h0028, 32'h1);
        rd_check("rd_ring_count", 16'h002C, 32'h1234);

        // Byte strobes
        axi_wr(16'h002C, 32'hABCD5678, 4'b0001);
        check("strb_ring_count", ring_count, 16'h1278);
        rd_check("rd_strb_ring", 16'h002C, 32'h1278);
        axi_wr(16'h0024, 32'h00A50000, 4'b0100);
        check("strb_outen", output_en, 33'h1FFA5FFFF);

        // Status inputs and RO/unmapped handling
        ring_counta = 16'hBEEF; ring_countb = 16'h0102;
        rd_check("ring_counta", 16'h0030, 32'hBEEF);
        rd_check("ring_countb", 16'h0034, 32'h0102);
        axi_wr(16'h0030, 32'h0, 4'hF);
        rd_check("ring_counta_ro", 16'h0030, 32'hBEEF);
        axi_wr(16'h0000, 32'hFFFF, 4'hF);
        rd_check("magic_ro", 16'h0000, 32'h00021EAF);
        axi_rd(16'h0100, d, resp, la, lr);
        check("unmapped", d, 0);
        check("unmapped_rresp", resp, 2'b00);

        // Address without data is not accepted
        @(negedge clk);
        awaddr = 16'h0020; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("aw_alone_wait", awready, 0);
        end
        wvalid = 1'b1;
        wr_wait_accept(la);
        wr_wait_resp(resp);
        @(posedge clk); #1;
        check("aw_then_w_enable", enable, 0);

        // bvalid held while bready low; second write blocked meanwhile
        bready = 1'b0;
        wr_start(16'h002C, 32'h1111, 4'b0011);
        wr_wait_accept(la);
        wr_wait_resp(resp);
        awaddr = 16'h002C; wdata = 32'h2222; wstrb = 4'b0011;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bhold_bvalid", bvalid, 1);
            check("bhold_awready", awready, 0);
        end
        check("bhold_ring_count", ring_count, 16'h1111);
        bready = 1'b1;
        wr_wait_accept(la);
        wr_wait_resp(resp);
        @(posedge clk); #1;
        check("after_bhold_ring", ring_count, 16'h2222);

        // Read and write of the same word on the same handshake edge
        @(negedge clk);
        awaddr = 16'h002C; wdata = 32'h3333; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 16'h002C; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        check("same_awready", awready, 1);
        check("same_arready", arready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check("same_bvalid", bvalid, 1);
        check("same_rvalid", rvalid, 1);
        check("same_rdata_old", rdata, 32'h2222);
        check("same_ring_new", ring_count, 16'h3333);
        @(posedge clk); #1;

        // Reset during a pending read response
        rready = 1'b0;
        @(negedge clk);
        araddr = 16'h0024; arvalid = 1'b1;
        rd_wait_accept(la);
        rd_wait_data(lr);
        check("pre_rst_rvalid", rvalid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_enable", enable, 0);
        check("mid_rst_output_en", output_en, 0);
        check("mid_rst_ring_count", ring_count, 0);
        @(negedge clk);
        rst = 1'b0;
        rd_check("post_rst_ring", 16'h002C, 0);
        rd_check("post_rst_magic", 16'h0000, 32'h00021EAF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
